// File: rtl/smpc_pad_scan.sv
// smpc_pad_scan
// Controller-port scanner feeding the SMPC INTBACK peripheral-data path.
// On a START pulse it walks the TH/TR select lines through four phases,
// samples one data nibble per phase after a settle delay, decides whether a
// standard digital pad is attached, and then emits the INTBACK peripheral
// byte stream over a valid/ready byte interface.
//
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset
//   CE         clock enable for scan timing (DRIVE/SETTLE/SAMPLE)
//   START      one-CLK scan request, ignored while BUSY
//   BUSY       high from accepted START until the last byte transfers
//   PI[6:0]    port pins: [3:0]=D3..D0, [4]=TL, [5]=TR, [6]=TH
//   PO[6:0]    port pin output values (only TH/TR ever non-zero)
//   PDDR[6:0]  port direction, 1=driven (TH/TR only)
//   BYTE_DO    stream byte
//   BYTE_VALID stream byte valid
//   BYTE_READY consumer accepts the byte
//   BYTE_LAST  marks the final byte of the stream
module smpc_pad_scan #(
  parameter int SETTLE_CYC = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       START,
  output logic       BUSY,
  input  logic [6:0] PI,
  output logic [6:0] PO,
  output logic [6:0] PDDR,
  output logic [7:0] BYTE_DO,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic       BYTE_LAST
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    EMIT
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] sel, sel_n;
  logic [3:0] n0, n1, n2, n3;
  logic [3:0] n0_n, n1_n, n2_n, n3_n;
  logic [1:0] byte_idx, byte_idx_n;
  logic       busy, busy_n;
  logic       valid, valid_n;
  logic       last, last_n;
  logic [7:0] do_r, do_n;

  logic       present;
  logic [7:0] stream_byte;
  logic       stream_last;

  // TH, TL and TR are inputs the scanner drives or ignores itself; the data
  // path only looks at D3..D0.
  logic unused_pins;
  assign unused_pins = ^PI[6:4];

  // A standard pad identifies itself through the low three bits of the
  // fourth nibble. Everything is active-low and passed through untouched.
  always_comb begin
    present     = (n3[2:0] == 3'b100);
    stream_byte = 8'h00;
    stream_last = 1'b0;
    if (!present) begin
      stream_byte = 8'hF0;
      stream_last = 1'b1;
    end else begin
      case (byte_idx)
        2'd0:    stream_byte = 8'hF1;
        2'd1:    stream_byte = 8'h02;
        2'd2:    stream_byte = {n2, n1};
        default: begin
          stream_byte = {n0, n3[3], 3'b111};
          stream_last = 1'b1;
        end
      endcase
    end
  end

  // Next-state logic. Scan timing (DRIVE/SETTLE/SAMPLE) only moves on CE,
  // whereas START capture and the byte handshake run on every CLK. In EMIT
  // a byte is loaded on one edge and retired on a later edge, which leaves
  // one idle cycle between consecutive bytes.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    sel_n      = sel;
    n0_n       = n0;
    n1_n       = n1;
    n2_n       = n2;
    n3_n       = n3;
    byte_idx_n = byte_idx;
    busy_n     = busy;
    valid_n    = valid;
    last_n     = last;
    do_n       = do_r;

    case (state)
      IDLE: begin
        if (START) begin
          state_n    = DRIVE;
          busy_n     = 1'b1;
          phase_n    = 2'd0;
          byte_idx_n = 2'd0;
        end
      end

      DRIVE: begin
        if (CE) begin
          sel_n   = phase;
          cnt_n   = SETTLE_LOAD;
          state_n = SETTLE;
        end
      end

      SETTLE: begin
        if (CE) begin
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) begin
            state_n = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (CE) begin
          case (phase)
            2'd0:    n0_n = PI[3:0];
            2'd1:    n1_n = PI[3:0];
            2'd2:    n2_n = PI[3:0];
            default: n3_n = PI[3:0];
          endcase
          if (phase != 2'd3) begin
            phase_n = phase + 2'd1;
            state_n = DRIVE;
          end else begin
            sel_n   = 2'b11;
            state_n = EMIT;
          end
        end
      end

      EMIT: begin
        if (!valid) begin
          valid_n = 1'b1;
          do_n    = stream_byte;
          last_n  = stream_last;
        end else if (BYTE_READY) begin
          valid_n = 1'b0;
          if (last) begin
            last_n  = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset abandons any scan or stream in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      phase    <= 2'd0;
      cnt      <= 8'd0;
      sel      <= 2'b11;
      n0       <= 4'hF;
      n1       <= 4'hF;
      n2       <= 4'hF;
      n3       <= 4'hF;
      byte_idx <= 2'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      last     <= 1'b0;
      do_r     <= 8'h00;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      sel      <= sel_n;
      n0       <= n0_n;
      n1       <= n1_n;
      n2       <= n2_n;
      n3       <= n3_n;
      byte_idx <= byte_idx_n;
      busy     <= busy_n;
      valid    <= valid_n;
      last     <= last_n;
      do_r     <= do_n;
    end
  end

  assign PO         = {sel, 5'b00000};
  assign PDDR       = 7'h60;
  assign BUSY       = busy;
  assign BYTE_DO    = do_r;
  assign BYTE_VALID = valid;
  assign BYTE_LAST  = last;

endmodule

// File: tb/tb_smpc_pad_scan.sv
// tb_smpc_pad_scan
// Bench for smpc_pad_scan. A pad model answers the TH/TR select lines with
// per-phase nibbles; a stream model derives the expected INTBACK bytes from
// those nibbles. One negedge process checks the pin outputs every cycle and
// every transferred byte against the model, plus handshake stability and the
// idle gap between bytes. Directed scans then pin stream contents, BUSY
// length and latency against hand-computed literals.
module tb_smpc_pad_scan;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       START;
  logic       BUSY;
  logic [6:0] PI;
  logic [6:0] PO;
  logic [6:0] PDDR;
  logic [7:0] BYTE_DO;
  logic       BYTE_VALID;
  logic       BYTE_READY;
  logic       BYTE_LAST;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] pad_nibs = 16'hFFFF;
  bit          pad_on   = 1'b0;
  int          ce_mode  = 0;
  int          div      = 0;
  int          bp_left  = 0;
  bit          checking = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         busy_cycles = 0;
  bit         hold_pending = 1'b0;
  bit         prev_xfer = 1'b0;
  logic [7:0] held_do;
  logic       held_last;

  smpc_pad_scan #(.SETTLE_CYC(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CE         (CE),
    .START      (START),
    .BUSY       (BUSY),
    .PI         (PI),
    .PO         (PO),
    .PDDR       (PDDR),
    .BYTE_DO    (BYTE_DO),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .BYTE_LAST  (BYTE_LAST)
  );

  always #5 CLK = ~CLK;

  // Stream model: {last, byte} entries straight from the presence rule and
  // the byte layout, with nibbles packed as {N3,N2,N1,N0}.
  function automatic int model_len(input logic [15:0] nibs);
    return (nibs[14:12] == 3'b100) ? 4 : 1;
  endfunction

  function automatic logic [8:0] model_byte(input logic [15:0] nibs, input int k);
    logic [3:0] m0, m1, m2, m3;
    m0 = nibs[3:0];
    m1 = nibs[7:4];
    m2 = nibs[11:8];
    m3 = nibs[15:12];
    if (m3[2:0] != 3'b100) return {1'b1, 8'hF0};
    case (k)
      0:       return {1'b0, 8'hF1};
      1:       return {1'b0, 8'h02};
      2:       return {1'b0, m2, m1};
      default: return {1'b1, m0, m3[3], 3'b111};
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // One CLK of stimulus: inputs change 1 time unit after the edge. The pad
  // model answers whatever select lines the DUT drives; backpressure holds
  // READY low while byte 02 is offered.
  task automatic step();
    int s;
    @(posedge CLK);
    #1;
    div = (div + 1) % 4;
    CE  = (ce_mode == 0) ? 1'b1 : (div == 0);
    s   = int'(PO[6:5]);
    if (pad_on) PI = {PO[6:5], 1'b1, pad_nibs[s*4 +: 4]};
    else        PI = 7'h7F;
    if (bp_left > 0 && BYTE_VALID && BYTE_DO == 8'h02) begin
      BYTE_READY = 1'b0;
      bp_left--;
    end else begin
      BYTE_READY = 1'b1;
    end
  endtask

  // Per-cycle checker: pin directions, byte order/content against the
  // model, stability under backpressure, and the idle gap after a transfer.
  always @(negedge CLK) begin
    if (checking) begin
      vectors++;
      if (PDDR !== 7'h60 || PO[4:0] !== 5'd0) begin
        miscompares++;
        $display("[TB] FAIL pins: PDDR %0h PO %0h, want PDDR 60 PO[4:0] 0", PDDR, PO);
      end
      if (!RST) begin
        if (BUSY) busy_cycles++;
        if (prev_xfer) begin
          vectors++;
          if (BYTE_VALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL byte_gap: VALID %0b right after a transfer, want 0", BYTE_VALID);
          end
        end
        if (BYTE_VALID === 1'b1) begin
          if (hold_pending) begin
            vectors++;
            if (BYTE_DO !== held_do || BYTE_LAST !== held_last) begin
              miscompares++;
              $display("[TB] FAIL hold: DO %0h LAST %0b, want DO %0h LAST %0b", BYTE_DO, BYTE_LAST, held_do, held_last);
            end
          end
          vectors++;
          if (BUSY !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_with_valid: BUSY %0b, want 1", BUSY);
          end
          if (BYTE_READY) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("[TB] FAIL extra_byte: got %0h, want none", {BYTE_LAST, BYTE_DO});
            end else begin
              logic [8:0] e;
              e = exp_q.pop_front();
              if ({BYTE_LAST, BYTE_DO} !== e) begin
                miscompares++;
                $display("[TB] FAIL stream_byte: got %0h, want %0h", {BYTE_LAST, BYTE_DO}, e);
              end
            end
            rx_q.push_back({BYTE_LAST, BYTE_DO});
            prev_xfer    = 1'b1;
            hold_pending = 1'b0;
          end else begin
            hold_pending = 1'b1;
            held_do      = BYTE_DO;
            held_last    = BYTE_LAST;
            prev_xfer    = 1'b0;
          end
        end else begin
          hold_pending = 1'b0;
          prev_xfer    = 1'b0;
        end
      end else begin
        hold_pending = 1'b0;
        prev_xfer    = 1'b0;
      end
    end
  end

  // Runs one complete scan. Returns the edge (counted from the START-accept
  // edge) at which the first byte became valid.
  task automatic apply_stimulus(input logic [15:0] nibs, input bit pad, input int mode,
                                input bit bp, input bit mid_start, output int first_valid);
    int cycles;
    int guard;
    logic [1:0] prev_sel;
    logic [1:0] sel_q[$];
    pad_nibs = nibs;
    pad_on   = pad;
    ce_mode  = mode;
    bp_left  = bp ? 5 : 0;
    exp_q.delete();
    rx_q.delete();
    for (int k = 0; k < model_len(nibs); k++) exp_q.push_back(model_byte(nibs, k));
    busy_cycles = 0;
    first_valid = -1;
    prev_sel    = PO[6:5];
    START = 1'b1;
    div   = 0;
    step();
    START  = 1'b0;
    cycles = 0;
    guard  = 0;
    while (BUSY && guard < 5000) begin
      START = (mid_start && cycles == 50);
      step();
      cycles++;
      guard++;
      if (first_valid < 0 && BYTE_VALID) first_valid = cycles;
      if (PO[6:5] != prev_sel) begin
        sel_q.push_back(PO[6:5]);
        prev_sel = PO[6:5];
      end
    end
    START = 1'b0;
    check_output("scan_timeout", 32'(guard < 5000), 32'd1);
    check_output("bytes_left", 32'(exp_q.size()), 32'd0);
    check_output("sel_changes", 32'(sel_q.size()), 32'd4);
    if (sel_q.size() == 4) begin
      check_output("sel_sequence", {sel_q[0], sel_q[1], sel_q[2], sel_q[3]}, 32'b00_01_10_11);
    end
    check_output("po_idle", 32'(PO), 32'h60);
  endtask

  task automatic check_stream(input string name, input logic [8:0] want[4], input int n);
    check_output({name, "_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) check_output(name, 32'(rx_q[i]), 32'(want[i]));
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (BUSY && guard < 5000) begin
      step();
      guard++;
    end
    check_output(name, 32'(guard < 5000), 32'd1);
  endtask

  initial begin
    int fv;
    int guard;
    RST        = 1'b1;
    CE         = 1'b1;
    START      = 1'b0;
    BYTE_READY = 1'b1;
    PI         = 7'h7F;
    step();
    checking = 1'b1;
    step();
    check_output("rst_po", 32'(PO), 32'h60);
    check_output("rst_pddr", 32'(PDDR), 32'h60);
    check_output("rst_busy", 32'(BUSY), 32'd0);
    check_output("rst_valid", 32'(BYTE_VALID), 32'd0);
    check_output("rst_last", 32'(BYTE_LAST), 32'd0);
    check_output("rst_do", 32'(BYTE_DO), 32'd0);
    RST = 1'b0;
    step();

    $display("[TB] pad present, no buttons");
    apply_stimulus(16'hCFFF, 1'b1, 0, 1'b0, 1'b0, fv);
    check_stream("pad_idle", '{9'h0F1, 9'h002, 9'h0FF, 9'h1FF}, 4);
    check_output("pad_idle_first_valid", 32'(fv), 32'd41);
    check_output("pad_idle_busy", 32'(busy_cycles), 32'd48);

    $display("[TB] pad with A and Up pressed");
    apply_stimulus(16'hCEDF, 1'b1, 0, 1'b0, 1'b0, fv);
    check_stream("pad_a_up", '{9'h0F1, 9'h002, 9'h0ED, 9'h1FF}, 4);

    $display("[TB] pad with N3[3] low");
    apply_stimulus(16'h4FFF, 1'b1, 0, 1'b0, 1'b0, fv);
    check_stream("pad_n3b3", '{9'h0F1, 9'h002, 9'h0FF, 9'h1F7}, 4);

    $display("[TB] no device");
    apply_stimulus(16'hFFFF, 1'b0, 0, 1'b0, 1'b0, fv);
    check_stream("no_dev", '{9'h1F0, 9'h000, 9'h000, 9'h000}, 1);
    check_output("no_dev_busy", 32'(busy_cycles), 32'd42);

    $display("[TB] backpressure on byte 2");
    apply_stimulus(16'hCFFF, 1'b1, 0, 1'b1, 1'b0, fv);
    check_stream("backpressure", '{9'h0F1, 9'h002, 9'h0FF, 9'h1FF}, 4);
    check_output("backpressure_busy", 32'(busy_cycles), 32'd53);

    $display("[TB] CE one cycle in four, START while busy");
    apply_stimulus(16'hCEDF, 1'b1, 1, 1'b0, 1'b1, fv);
    check_stream("ce_quarter", '{9'h0F1, 9'h002, 9'h0ED, 9'h1FF}, 4);
    check_output("ce_quarter_first_valid", 32'(fv), 32'd161);
    check_output("ce_quarter_busy", 32'(busy_cycles), 32'd168);
    ce_mode = 0;
    step();

    $display("[TB] START on the final transfer edge and the one after");
    pad_on = 1'b0;
    exp_q.delete();
    rx_q.delete();
    exp_q.push_back({1'b1, 8'hF0});
    exp_q.push_back({1'b1, 8'hF0});
    START = 1'b1;
    step();
    START = 1'b0;
    guard = 0;
    while (!(BYTE_VALID && BYTE_LAST) && guard < 500) begin
      step();
      guard++;
    end
    check_output("last_wait", 32'(guard < 500), 32'd1);
    START = 1'b1;
    step();
    check_output("start_at_last_ignored", 32'(BUSY), 32'd0);
    step();
    START = 1'b0;
    check_output("start_next_accepted", 32'(BUSY), 32'd1);
    wait_idle("second_scan_timeout");
    check_output("back_to_back_bytes", 32'(rx_q.size()), 32'd2);
    check_output("back_to_back_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset during settle of phase 2");
    pad_nibs = 16'hCFFF;
    pad_on   = 1'b1;
    exp_q.delete();
    rx_q.delete();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 1; i <= 24; i++) step();
    check_output("pre_reset_sel", 32'(PO[6:5]), 32'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_output("mid_rst_po", 32'(PO), 32'h60);
    check_output("mid_rst_busy", 32'(BUSY), 32'd0);
    check_output("mid_rst_valid", 32'(BYTE_VALID), 32'd0);
    for (int i = 0; i < 50; i++) step();
    check_output("mid_rst_stays_idle", 32'(BUSY), 32'd0);
    check_output("mid_rst_no_bytes", 32'(rx_q.size()), 32'd0);
    apply_stimulus(16'hCFFF, 1'b1, 0, 1'b0, 1'b0, fv);
    check_stream("after_reset", '{9'h0F1, 9'h002, 9'h0FF, 9'h1FF}, 4);
    check_output("after_reset_busy", 32'(busy_cycles), 32'd48);

    step();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
